lfsr_range_sampler: RTL



---
 rtl/lfsr_range_sampler_if.sv | 22 ++
 rtl/lfsr_range_sampler.sv | 135 +++++++++++++
 2 files changed

// File: rtl/lfsr_range_sampler_if.sv
// Request/response bundle for lfsr_range_sampler: the consumer drives the master side,
// and the sampler drives the slave side.
interface lfsr_range_sampler_if #(parameter int W = 8);
  logic         req_valid_i;
  logic [W-1:0] req_bound_i;
  logic         req_ready_o;
  logic         sample_valid_o;
  logic [W-1:0] sample_o;
  logic         sample_fallback_o;
  logic         sample_ready_i;
  logic [15:0]  reject_total_o;

  modport master (
    output req_valid_i, req_bound_i, sample_ready_i,
    input  req_ready_o, sample_valid_o, sample_o, sample_fallback_o, reject_total_o
  );

  modport slave (
    input  req_valid_i, req_bound_i, sample_ready_i,
    output req_ready_o, sample_valid_o, sample_o, sample_fallback_o, reject_total_o
  );
endinterface

// File: rtl/lfsr_range_sampler.sv
// Mask-and-reject sampler that turns LFSR words into uniform values in [0, bound).
// Define LFSR_RANGE_SAMPLER_STATS_EN to build the saturating reject_total_o counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | ready for a request; bound and mask are latched on accept
// S_SAMPLE | the candidate pipeline is registered; one candidate is judged per cycle
// S_VALID  | the result is held stable until the consumer takes it
module lfsr_range_sampler #(
  parameter int W         = 8,
  parameter int MAX_TRIES = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [31:0]             rand_i,
  lfsr_range_sampler_if.slave     bus
);

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_VALID} state_t;

  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

  state_t       state_q;
  logic [W-1:0] bound_q;
  logic [W-1:0] mask_q;
  logic [W-1:0] cand_q;
  logic         cand_vld_q;
  logic [3:0]   try_q;
  logic         req_ready_q;
  logic         sample_valid_q;
  logic [W-1:0] sample_q;
  logic         fallback_q;

  logic [W-1:0] bound_m1;
  logic [W-1:0] mask_d;
  logic         hit;
  logic         reject_evt;
  logic         unused_rand_hi;

  assign unused_rand_hi = ^rand_i[31:W];

  // Smear the top set bit of bound-1 downward; bound 0 wraps to an all-ones mask.
  always_comb begin
    bound_m1 = bus.req_bound_i - W'(1);
    mask_d   = bound_m1;
    for (int i = 1; i < W; i++) begin
      mask_d = mask_d | (bound_m1 >> i);
    end
  end

  assign hit        = (bound_q == '0) || (cand_q < bound_q);
  assign reject_evt = (state_q == S_SAMPLE) && cand_vld_q && !hit;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      bound_q        <= '0;
      mask_q         <= '0;
      cand_q         <= '0;
      cand_vld_q     <= 1'b0;
      try_q          <= '0;
      req_ready_q    <= 1'b1;
      sample_valid_q <= 1'b0;
      sample_q       <= '0;
      fallback_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            bound_q     <= bus.req_bound_i;
            mask_q      <= mask_d;
            try_q       <= '0;
            cand_vld_q  <= 1'b0;
            req_ready_q <= 1'b0;
            state_q     <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          // Candidates are registered first, so the first judgement lands one cycle after entry.
          cand_q     <= rand_i[W-1:0] & mask_q;
          cand_vld_q <= 1'b1;
          if (cand_vld_q && hit) begin
            sample_q       <= cand_q;
            fallback_q     <= 1'b0;
            sample_valid_q <= 1'b1;
            state_q        <= S_VALID;
          end else if (reject_evt) begin
            try_q <= try_q + 4'd1;
            if (try_q == LAST_TRY) begin
              // mask+1 < 2*bound, so cand-bound always lands inside the range.
              sample_q       <= cand_q - bound_q;
              fallback_q     <= 1'b1;
              sample_valid_q <= 1'b1;
              state_q        <= S_VALID;
            end
          end
        end
        S_VALID: begin
          if (bus.sample_ready_i) begin
            sample_valid_q <= 1'b0;
            req_ready_q    <= 1'b1;
            state_q        <= S_IDLE;
          end
        end
        default: begin
          state_q        <= S_IDLE;
          req_ready_q    <= 1'b1;
          sample_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef LFSR_RANGE_SAMPLER_STATS_EN
  logic [15:0] reject_total_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      reject_total_q <= '0;
    end else if (reject_evt && (reject_total_q != 16'hFFFF)) begin
      reject_total_q <= reject_total_q + 16'd1;
    end
  end

  assign bus.reject_total_o = reject_total_q;
`else
  assign bus.reject_total_o = 16'd0;
`endif

  assign bus.req_ready_o       = req_ready_q;
  assign bus.sample_valid_o    = sample_valid_q;
  assign bus.sample_o          = sample_q;
  assign bus.sample_fallback_o = fallback_q;

endmodule
